// File: rtl/size_up_fifo_ctrl.sv
// size_up_fifo_ctrl: packs RATIO narrow write beats into one wide word
// and queues complete words in a small FIFO with a registered pop port.
// Optional build macro: SIZE_UP_FIFO_LEVEL_EN adds rd_water_level.
// Ports:
//   clk, rst         clock, async active-high reset
//   wr_en, wr_data   write beat (accepted when full=0)
//   full             no beat accepted
//   rd_en            pop request (honoured when empty=0)
//   rd_data          popped word, valid with the rd_valid pulse
//   empty            no complete word stored
//   rd_water_level   stored complete words (macro builds only)
module size_up_fifo_ctrl #(
   parameter  int ADDR_WIDTH = 4,
   parameter  int IN_WIDTH   = 8,
   parameter  int RATIO      = 4,
   localparam int OUT_WIDTH  = IN_WIDTH * RATIO
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [IN_WIDTH-1:0]  wr_data,
   output logic                 full,
   input  logic                 rd_en,
   output logic [OUT_WIDTH-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 empty
`ifdef SIZE_UP_FIFO_LEVEL_EN
  ,output logic [ADDR_WIDTH:0]  rd_water_level
`endif
);

   localparam int LW    = $clog2(RATIO);
   localparam int PW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [LW-1:0]        lane;
   logic [OUT_WIDTH-1:0] pack;
   logic [OUT_WIDTH-1:0] word;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        count;
   logic                 accept;
   logic                 last;
   logic                 push;
   logic                 pop;

   logic [OUT_WIDTH-1:0] mem [DEPTH];

   // Flags come only from the pointer registers, never from wr_en/rd_en.
   assign count  = wr_ptr - rd_ptr;
   assign full   = (count == PW'(DEPTH));
   assign empty  = (count == '0);

   assign accept = wr_en & ~full;
   assign last   = (lane == LW'(RATIO - 1));
   assign push   = accept & last;
   assign pop    = rd_en & ~empty;

   // Packing register with the current beat merged into its lane.
   always_comb begin
      word = pack;
      word[lane*IN_WIDTH +: IN_WIDTH] = wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane     <= '0;
         pack     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (accept) begin
            lane <= last ? '0 : lane + 1'b1;
            pack <= last ? '0 : word;
         end
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
         end
         rd_valid <= pop;
      end
   end

   // Word storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= word;
   end

`ifdef SIZE_UP_FIFO_LEVEL_EN
   logic [PW-1:0] wr_nxt;
   logic [PW-1:0] rd_nxt;

   assign wr_nxt = wr_ptr + PW'(push);
   assign rd_nxt = rd_ptr + PW'(pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_water_level <= '0;
      else
         rd_water_level <= wr_nxt - rd_nxt;
   end
`endif

endmodule

// File: tb/tb_size_up_fifo_ctrl.sv
// tb_size_up_fifo_ctrl: directed checks of the beat packer and FIFO.
// Default parameters: ADDR_WIDTH=4, IN_WIDTH=8, RATIO=4.
module tb_size_up_fifo_ctrl;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        full;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        empty;
`ifdef SIZE_UP_FIFO_LEVEL_EN
   logic [4:0]  rd_water_level;
`endif

   int n_cmp;
   int n_bad;

   size_up_fifo_ctrl #(
      .ADDR_WIDTH(4),
      .IN_WIDTH  (8),
      .RATIO     (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .rd_valid(rd_valid),
      .empty   (empty)
`ifdef SIZE_UP_FIFO_LEVEL_EN
     ,.rd_water_level(rd_water_level)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic lvl(input string tag, input int exp);
`ifdef SIZE_UP_FIFO_LEVEL_EN
      chk(tag, 64'(rd_water_level), 64'(exp));
`endif
   endtask

   // One clock: drive, take the edge, sample 1 time unit later.
   task automatic cyc(input logic we, input logic [7:0] wd,
                      input logic re);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   function automatic logic [7:0] ilv_beat(input int w, input int j);
      return 8'((w * 4 + j) ^ 8'h3c);
   endfunction

   function automatic logic [31:0] ilv_word(input int w);
      return {ilv_beat(w, 3), ilv_beat(w, 2),
              ilv_beat(w, 1), ilv_beat(w, 0)};
   endfunction

   logic [31:0] exp_w;

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en   = 1'b0;
      rst     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_valid", 64'(rd_valid), 64'd0);
      chk("rst_data", 64'(rd_data), 64'd0);
      lvl("rst_lvl", 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // pop on empty is ignored
      cyc(1'b0, 8'h00, 1'b1);
      chk("pop_empty_valid", 64'(rd_valid), 64'd0);
      chk("pop_empty_data", 64'(rd_data), 64'd0);

      // basic pack and pop
      cyc(1'b1, 8'h11, 1'b0);
      cyc(1'b1, 8'h22, 1'b0);
      cyc(1'b1, 8'h33, 1'b0);
      chk("partial_empty", 64'(empty), 64'd1);
      lvl("partial_lvl", 0);
      cyc(1'b1, 8'h44, 1'b0);
      chk("word_empty", 64'(empty), 64'd0);
      lvl("word_lvl", 1);
      cyc(1'b0, 8'h00, 1'b1);
      chk("pop_valid", 64'(rd_valid), 64'd1);
      chk("pop_data", 64'(rd_data), 64'h44332211);
      chk("pop_empty", 64'(empty), 64'd1);
      cyc(1'b0, 8'h00, 1'b0);
      chk("idle_valid", 64'(rd_valid), 64'd0);
      chk("idle_data_hold", 64'(rd_data), 64'h44332211);

      // fill to full with 64 beats, beat value = index
      for (int i = 0; i < 64; i++) begin
         cyc(1'b1, 8'(i), 1'b0);
         if (i == 59)
            chk("fill60_full", 64'(full), 64'd0);
      end
      chk("fill_full", 64'(full), 64'd1);
      lvl("fill_lvl", 16);
      cyc(1'b1, 8'hee, 1'b0);
      chk("drop_full", 64'(full), 64'd1);
      lvl("drop_lvl", 16);

      // full, beat and pop together: beat dropped, one word leaves
      cyc(1'b1, 8'hef, 1'b1);
      chk("combo_valid", 64'(rd_valid), 64'd1);
      chk("combo_data", 64'(rd_data), 64'h03020100);
      chk("combo_full", 64'(full), 64'd0);
      lvl("combo_lvl", 15);
      for (int w = 1; w < 16; w++) begin
         exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
         cyc(1'b0, 8'h00, 1'b1);
         chk("drain_data", 64'(rd_data), 64'(exp_w));
         chk("drain_valid", 64'(rd_valid), 64'd1);
      end
      chk("drain_empty", 64'(empty), 64'd1);
      lvl("drain_lvl", 0);

      // dropped beats must not have entered the lanes
      cyc(1'b1, 8'ha0, 1'b0);
      cyc(1'b1, 8'ha1, 1'b0);
      cyc(1'b1, 8'ha2, 1'b0);
      cyc(1'b1, 8'ha3, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("after_drop_data", 64'(rd_data), 64'ha3a2a1a0);

      // reset mid-packing, checked before any clock edge
      cyc(1'b1, 8'haa, 1'b0);
      cyc(1'b1, 8'hbb, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_data", 64'(rd_data), 64'd0);
      chk("async_rst_empty", 64'(empty), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b1, 8'h01, 1'b0);
      cyc(1'b1, 8'h02, 1'b0);
      cyc(1'b1, 8'h03, 1'b0);
      cyc(1'b1, 8'h04, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("rst_mid_data", 64'(rd_data), 64'h04030201);

      // interleaved traffic, 40 words, pointers wrap past 32
      for (int w = 0; w < 40; w++) begin
         for (int j = 0; j < 4; j++) begin
            cyc(1'b1, ilv_beat(w, j), (j == 0 && w >= 3));
            if (j == 0 && w >= 3) begin
               chk("ilv_valid", 64'(rd_valid), 64'd1);
               chk("ilv_data", 64'(rd_data), 64'(ilv_word(w - 3)));
            end
         end
         chk("ilv_full", 64'(full), 64'd0);
         chk("ilv_empty", 64'(empty), 64'd0);
      end
      lvl("ilv_lvl", 3);
      for (int w = 37; w < 40; w++) begin
         cyc(1'b0, 8'h00, 1'b1);
         chk("ilv_tail", 64'(rd_data), 64'(ilv_word(w)));
      end
      chk("ilv_end_empty", 64'(empty), 64'd1);
      cyc(1'b0, 8'h00, 1'b1);
      chk("ilv_end_valid", 64'(rd_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/size_up_fifo_ctrl.md
SIZE_UP_FIFO_CTRL -- requirements
Module: size_up_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: word-address width, range 4-10, depth 2**ADDR_WIDTH output words.
REQ-002 SHALL have parameter IN_WIDTH, default 8: write beat width, range 1-64.
REQ-003 SHALL have parameter RATIO, default 4: input beats per output word, legal 2, 4 or 8.
REQ-004 SHALL define OUT_WIDTH = IN_WIDTH*RATIO as a derived localparam, not overridable.
REQ-005 SHALL use one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 wr_en  input  1  write beat request.
REQ-009 wr_data  input  IN_WIDTH  write beat.
REQ-010 full  output  1  no write beat accepted.
REQ-011 rd_en  input  1  pop request.
REQ-012 rd_data  output  OUT_WIDTH  popped word, registered.
REQ-013 rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-014 empty  output  1  no complete word stored.
REQ-015 rd_water_level  output  ADDR_WIDTH+1  stored complete words; present only under SIZE_UP_FIFO_LEVEL_EN.

Function
REQ-016 SHALL accept a beat when wr_en=1 and full=0 at the clock edge; beats with full=1 SHALL be dropped with no state change.
REQ-017 SHALL place accepted beat k (k=0..RATIO-1, lane counter) at bits [k*IN_WIDTH +: IN_WIDTH]; first beat in LSBs.
REQ-018 SHALL, on the beat with lane counter = RATIO-1, write the complete word into internal storage at wr_ptr, increment wr_ptr, reset lane counter to 0.
REQ-019 SHALL pop when rd_en=1 and empty=0: rd_data <= word at rd_ptr, rd_valid=1 in the next cycle, rd_ptr increments; read latency exactly 1 clock.
REQ-020 SHALL ignore rd_en while empty=1; rd_valid=0, rd_data holds last value.
REQ-021 SHALL keep rd_valid=0 in every cycle with no accepted pop.
REQ-022 SHALL use ADDR_WIDTH+1-bit pointers wrapping modulo 2**(ADDR_WIDTH+1); word count = wr_ptr - rd_ptr.
REQ-023 full SHALL be 1 iff word count = 2**ADDR_WIDTH; empty SHALL be 1 iff word count = 0; both registered-state derived, no combinational path from wr_en/rd_en.
REQ-024 Word completion and pop in the same cycle SHALL leave word count unchanged; when full=1 the completing beat SHALL be dropped even if a pop occurs that cycle.
REQ-025 Partial words in the packing register SHALL not count toward empty, full or rd_water_level.
REQ-026 Storage SHALL be a 2**ADDR_WIDTH x OUT_WIDTH distributed array, written synchronously, read address registered into rd_data; contents not reset.

Reset
REQ-027 rst=1 SHALL immediately clear wr_ptr, rd_ptr, lane counter, packing register, rd_data (0), rd_valid (0), full (0), set empty (1), rd_water_level (0).
REQ-028 Reset mid-packing SHALL discard the partial word; next accepted beat is lane 0.
REQ-029 Deassertion SHALL be honored at the first clk edge after rst falls; no beat or pop accepted while rst=1.

Configuration
REQ-030 With SIZE_UP_FIFO_LEVEL_EN defined: rd_water_level port exists, registered, equals word count after every edge.
REQ-031 Without SIZE_UP_FIFO_LEVEL_EN: port and its logic absent; all other behaviour identical.

Verification (ADDR_WIDTH=4, IN_WIDTH=8, RATIO=4)
REQ-032 Beats 0x11,0x22,0x33,0x44, then rd_en one cycle -> next cycle rd_valid=1, rd_data=0x44332211, empty=1.
REQ-033 64 consecutive beats -> full=1 after 64th; 65th beat dropped; 16 pops return words in order, then empty=1.
REQ-034 rd_en on empty after reset -> rd_valid=0, rd_data=0x00000000.
REQ-035 full=1, rd_en=1 with a 4th beat in same cycle -> beat dropped, 15 words stored, full=0, rd_water_level=15.
REQ-036 Two beats 0xAA,0xBB, rst pulse, beats 0x01..0x04, pop -> rd_data=0x04030201.
REQ-037 Interleaved write/read of 40 words -> pointer wrap, all data in order, no spurious full/empty.
